servant_ram_arbiter: RTL and testbench

//  Two-master Wishbone arbiter that shares one servant RAM port (registered ack, 1-cycle read data)

---
 rtl/servant_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_servant_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_ram_arbiter.sv
// -----------------------------------------------------------------------------
// servant_ram_arbiter
//
// Shares one servant RAM Wishbone port between two masters:
//   master 0 - CPU data bus
//   master 1 - debug / loader bus
//
// Only one transaction is granted at a time. Ties go to the master that did
// not own the previous grant (round-robin), or always to master 0 when
// FIXED_PRIO is nonzero. Every grant is followed by a one-cycle release (REL)
// with the RAM cyc low. The RAM acks on cyc & !ack, so holding cyc high
// across two back-to-back grants would produce a false ack.
//
// A watchdog aborts a grant the RAM never acks. It sets a sticky o_timeout
// and never sends an ack to the stalled master.
//
// Parameters
//   AW          byte-address width of the RAM (word address is [AW-1:2])
//   FIXED_PRIO  0 = round-robin on ties, nonzero = master 0 wins ties
//   TIMEOUT     cycles in a BUS state without ack before abort (1..255)
//
// Ports
//   i_wb_clk, i_wb_rst_n          clock, asynchronous active-low reset
//   i_m0_* / o_m0_ack             master 0 request (adr/dat/sel/we/cyc) and ack
//   i_m1_* / o_m1_ack             master 1 request (adr/dat/sel/we/cyc) and ack
//   o_m_rdt                       RAM read data, broadcast to both masters
//   o_s_adr/dat/sel/we/cyc        request forwarded to the RAM
//   i_s_rdt, i_s_ack              RAM read data and ack
//   o_grant                       one-hot current owner {m1,m0}, 00 when idle
//   o_timeout                     sticky watchdog-abort flag, cleared by reset
// -----------------------------------------------------------------------------
module servant_ram_arbiter #(
    parameter int AW         = 8,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst_n,

    input  logic [AW-3:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic          o_m0_ack,

    input  logic [AW-3:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic          o_m1_ack,

    output logic [31:0]   o_m_rdt,

    output logic [AW-3:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,

    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    // The timer only ever reaches TIMEOUT-1 before the FSM leaves BUS,
    // so this width can never wrap.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t        state;
    logic          last_owner;   // owner of the most recent grant (0 = m0, 1 = m1)
    logic [TW-1:0] timer;

    // cyc of whichever master currently owns the bus (0 outside BUS states)
    logic owner_cyc;
    assign owner_cyc = (state == BUS0) ? i_m0_cyc :
                       (state == BUS1) ? i_m1_cyc : 1'b0;

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every branch reads
    // the pre-edge values of state, timer and last_owner.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;      // makes master 0 win the first tie
            timer      <= '0;
            o_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (i_m0_cyc && i_m1_cyc) begin
                        // Tie: fixed priority favours m0, otherwise the
                        // master that did not own the last grant wins.
                        if (FIXED_PRIO != 0 || last_owner)
                            state <= BUS0;
                        else
                            state <= BUS1;
                    end else if (i_m0_cyc) begin
                        state <= BUS0;
                    end else if (i_m1_cyc) begin
                        state <= BUS1;
                    end
                end

                BUS0, BUS1: begin
                    // Ack takes precedence over both a cyc drop and timer
                    // expiry in the same cycle: the ack is forwarded and the
                    // watchdog flag stays clear.
                    if (i_s_ack || !owner_cyc) begin
                        state      <= REL;
                        last_owner <= (state == BUS1);
                    end else if (timer == TIMER_LAST) begin
                        state      <= REL;
                        last_owner <= (state == BUS1);
                        o_timeout  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                REL: begin
                    timer <= '0;
                    state <= IDLE;
                end

                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath mux and handshake routing
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        o_s_adr  = '0;
        o_s_dat  = '0;
        o_s_sel  = '0;
        o_s_we   = 1'b0;
        o_s_cyc  = 1'b0;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_grant  = 2'b00;

        case (state)
            BUS0: begin
                o_s_adr  = i_m0_adr;
                o_s_dat  = i_m0_dat;
                o_s_sel  = i_m0_sel;
                o_s_we   = i_m0_we;
                o_s_cyc  = i_m0_cyc;
                o_m0_ack = i_s_ack;
                o_grant  = 2'b01;
            end
            BUS1: begin
                o_s_adr  = i_m1_adr;
                o_s_dat  = i_m1_dat;
                o_s_sel  = i_m1_sel;
                o_s_we   = i_m1_we;
                o_s_cyc  = i_m1_cyc;
                o_m1_ack = i_s_ack;
                o_grant  = 2'b10;
            end
            default: begin
                // IDLE and REL: RAM sees no request, masters see no ack.
            end
        endcase
    end

    // Read data is only meaningful alongside the owning master's ack.
    assign o_m_rdt = i_s_rdt;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_servant_ram_arbiter
//
// Directed bench for servant_ram_arbiter. Two instances share the master
// stimulus: "rr" (FIXED_PRIO=0) sits on a behavioural servant RAM
// (registered ack on cyc & !ack, one-cycle read data, byte-lane writes, and a
// stub mode that never acks); "fp" (FIXED_PRIO=1) only needs an ack generator.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_servant_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0]  m0_adr = '0, m1_adr = '0;
    logic [31:0] m0_dat = '0, m1_dat = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic        m0_cyc = 1'b0, m1_cyc = 1'b0;

    // round-robin instance
    logic        rr_m0_ack, rr_m1_ack, rr_s_we, rr_s_cyc, rr_timeout;
    logic [31:0] rr_rdt, rr_s_dat, rr_s_rdt;
    logic [5:0]  rr_s_adr;
    logic [3:0]  rr_s_sel;
    logic [1:0]  rr_grant;
    logic        rr_s_ack;

    // fixed-priority instance
    logic        fp_m0_ack, fp_m1_ack, fp_s_we, fp_s_cyc, fp_timeout;
    logic [31:0] fp_rdt, fp_s_dat, fp_s_rdt;
    logic [5:0]  fp_s_adr;
    logic [3:0]  fp_s_sel;
    logic [1:0]  fp_grant;
    logic        fp_s_ack;

    servant_ram_arbiter #(.AW(8), .FIXED_PRIO(0), .TIMEOUT(15)) dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
        .i_m0_cyc(m0_cyc), .o_m0_ack(rr_m0_ack),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .o_m1_ack(rr_m1_ack),
        .o_m_rdt(rr_rdt),
        .o_s_adr(rr_s_adr), .o_s_dat(rr_s_dat), .o_s_sel(rr_s_sel), .o_s_we(rr_s_we),
        .o_s_cyc(rr_s_cyc), .i_s_rdt(rr_s_rdt), .i_s_ack(rr_s_ack),
        .o_grant(rr_grant), .o_timeout(rr_timeout)
    );

    servant_ram_arbiter #(.AW(8), .FIXED_PRIO(1), .TIMEOUT(15)) dut_fp (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
        .i_m0_cyc(m0_cyc), .o_m0_ack(fp_m0_ack),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .o_m1_ack(fp_m1_ack),
        .o_m_rdt(fp_rdt),
        .o_s_adr(fp_s_adr), .o_s_dat(fp_s_dat), .o_s_sel(fp_s_sel), .o_s_we(fp_s_we),
        .o_s_cyc(fp_s_cyc), .i_s_rdt(fp_s_rdt), .i_s_ack(fp_s_ack),
        .o_grant(fp_grant), .o_timeout(fp_timeout)
    );

    // Behavioural servant RAM behind the round-robin instance
    logic [31:0] mem [64];
    logic        ram_stub = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_s_ack <= 1'b0;
        end else begin
            rr_s_ack <= rr_s_cyc && !rr_s_ack && !ram_stub;
            if (rr_s_cyc && rr_s_we && !rr_s_ack && !ram_stub)
                for (int b = 0; b < 4; b++)
                    if (rr_s_sel[b]) mem[rr_s_adr][8*b +: 8] <= rr_s_dat[8*b +: 8];
            rr_s_rdt <= mem[rr_s_adr];
        end
    end

    // Ack generator behind the fixed-priority instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fp_s_ack <= 1'b0;
        else        fp_s_ack <= fp_s_cyc && !fp_s_ack;
    end
    assign fp_s_rdt = fp_s_dat ^ {26'd0, fp_s_adr} ^ {28'd0, fp_s_sel} ^ {31'd0, fp_s_we};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One Wishbone transaction on the rr instance. Holds cyc until the ack
    // edge, drops it, then idles one cycle so the next call starts in IDLE.
    task automatic xfer(input bit m, input logic [5:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we,
                        output logic [31:0] rdt, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rdt = '0;
        if (m) begin
            m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_cyc = 1'b1;
        end else begin
            m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_cyc = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (m ? rr_m1_ack : rr_m0_ack) begin
                got = 1'b1;
                rdt = rr_rdt;
                check("other_ack", {31'd0, m ? rr_m0_ack : rr_m1_ack}, 32'd0);
                check("owner_grant", {30'd0, rr_grant}, m ? 32'd2 : 32'd1);
                check("s_adr_mux", {26'd0, rr_s_adr}, {26'd0, adr});
            end
        end
        check("xfer_acked", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (m) m1_cyc = 1'b0;
        else   m0_cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] rdt;
        int          lat;
        logic [1:0]  rr_seq [4];
        logic [1:0]  fp_seq [4];
        int          ack_cyc [4];
        int          rr_n, fp_n, na, fp_m1_acks, n_bus0, n_ack0;
        logic [1:0]  rr_prev, fp_prev;

        // ---------------- reset state ----------------
        #1;
        check("rst_grant", {30'd0, rr_grant}, 32'd0);
        check("rst_s_cyc", {31'd0, rr_s_cyc}, 32'd0);
        check("rst_acks", {30'd0, rr_m1_ack, rr_m0_ack}, 32'd0);
        check("rst_timeout", {31'd0, rr_timeout}, 32'd0);
        reset_pulse();

        // ---------------- 1: m0 write then read ----------------
        m1_adr = 6'h3F; m1_dat = 32'hFFFF_FFFF;   // decoy on the idle master
        xfer(1'b0, 6'h04, 32'hDEAD_BEEF, 4'hF, 1'b1, rdt, lat);
        check("t1_wr_lat", lat, 32'd2);
        xfer(1'b0, 6'h04, 32'h0, 4'hF, 1'b0, rdt, lat);
        check("t1_rd_lat", lat, 32'd2);
        check("t1_rd_data", rdt, 32'hDEAD_BEEF);

        // ---------------- 4: m1 partial write ----------------
        xfer(1'b1, 6'h08, 32'h1122_3344, 4'hF, 1'b1, rdt, lat);
        xfer(1'b1, 6'h08, 32'h0000_AB00, 4'b0010, 1'b1, rdt, lat);
        xfer(1'b1, 6'h08, 32'h0, 4'hF, 1'b0, rdt, lat);
        check("t4_m1_rd", rdt, 32'h1122_AB44);
        xfer(1'b0, 6'h08, 32'h0, 4'hF, 1'b0, rdt, lat);
        check("t4_m0_rd", rdt, 32'h1122_AB44);

        // ---------------- 2 + 3: both masters hold cyc ----------------
        reset_pulse();
        m0_adr = 6'h01; m0_we = 1'b0; m1_adr = 6'h02; m1_we = 1'b0;
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        rr_n = 0; fp_n = 0; na = 0; fp_m1_acks = 0;
        rr_prev = 2'b00; fp_prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            rr_seq[k] = 2'b00; fp_seq[k] = 2'b00; ack_cyc[k] = 0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (rr_grant != 2'b00 && rr_prev == 2'b00 && rr_n < 4) begin
                rr_seq[rr_n] = rr_grant; rr_n++;
            end
            if (fp_grant != 2'b00 && fp_prev == 2'b00 && fp_n < 4) begin
                fp_seq[fp_n] = fp_grant; fp_n++;
            end
            rr_prev = rr_grant;
            fp_prev = fp_grant;
            if ((rr_m0_ack || rr_m1_ack) && na < 4) begin
                ack_cyc[na] = c; na++;
            end
            if (fp_m1_ack) fp_m1_acks++;
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        check("t2_g0", {30'd0, rr_seq[0]}, 32'd1);
        check("t2_g1", {30'd0, rr_seq[1]}, 32'd2);
        check("t2_g2", {30'd0, rr_seq[2]}, 32'd1);
        check("t2_g3", {30'd0, rr_seq[3]}, 32'd2);
        check("t2_first_ack", ack_cyc[0], 32'd2);
        check("t2_ack_gap1", ack_cyc[1] - ack_cyc[0], 32'd4);
        check("t2_ack_gap2", ack_cyc[2] - ack_cyc[1], 32'd4);
        check("t2_ack_gap3", ack_cyc[3] - ack_cyc[2], 32'd4);
        for (int k = 0; k < 4; k++)
            check("t3_fp_grant", {30'd0, fp_seq[k]}, 32'd1);
        check("t3_m1_starved", fp_m1_acks, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // ---------------- 5: watchdog ----------------
        reset_pulse();
        ram_stub = 1'b1;
        m0_adr = 6'h01; m0_we = 1'b0; m0_cyc = 1'b1;
        n_bus0 = 0; n_ack0 = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rr_m0_ack) n_ack0++;
            if (rr_grant == 2'b01) n_bus0++;
            else if (n_bus0 > 0) break;
        end
        check("t5_bus0_len", n_bus0, 32'd15);
        check("t5_no_m0_ack", n_ack0, 32'd0);
        check("t5_timeout", {31'd0, rr_timeout}, 32'd1);
        m0_cyc = 1'b0;
        ram_stub = 1'b0;
        xfer(1'b1, 6'h08, 32'h0, 4'hF, 1'b0, rdt, lat);
        check("t5_m1_lat", lat, 32'd3);
        check("t5_m1_rd", rdt, 32'h1122_AB44);
        check("t5_sticky", {31'd0, rr_timeout}, 32'd1);

        // ---------------- 6: reset during BUS1 ----------------
        m1_adr = 6'h08; m1_we = 1'b0; m1_cyc = 1'b1;
        @(posedge clk); #1;
        check("t6_bus1", {30'd0, rr_grant}, 32'd2);
        check("t6_bus1_cyc", {31'd0, rr_s_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        m0_cyc = 1'b1;
        #1;
        check("t6_rst_cyc", {31'd0, rr_s_cyc}, 32'd0);
        check("t6_rst_grant", {30'd0, rr_grant}, 32'd0);
        check("t6_rst_acks", {30'd0, rr_m1_ack, rr_m0_ack}, 32'd0);
        check("t6_rst_timeout", {31'd0, rr_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_m0_wins", {30'd0, rr_grant}, 32'd1);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
